// File: rtl/hdmi_frame_reader_pkg.sv
// hdmi_frame_reader_pkg: AXI constants, FSM encoding and frame-size helper shared by the frame reader.
package hdmi_frame_reader_pkg;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, ABORT, DONE} state_t;

    // 24bpp packed into 32-bit words: every 4 pixels occupy 3 words
    function automatic logic [26:0] words_for(input logic [25:0] px);
        return 27'((28'(px) * 28'd3) >> 2);
    endfunction
endpackage

// File: rtl/hdmi_frame_reader_sync_fifo.sv
// hdmi_frame_reader_sync_fifo: single-clock FIFO with occupancy count and synchronous flush.
module hdmi_frame_reader_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                       clk_sys,
    input  logic                       rst_sys_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/hdmi_frame_reader.sv
// hdmi_frame_reader: fetches a packed 24bpp frame over AXI4 reads and replays it as a pixel stream.
module hdmi_frame_reader
    import hdmi_frame_reader_pkg::*;
#(
    parameter int BURST_SIZE         = 128,
    parameter int MAX_OUTSTANDING_TR = 2,
    parameter int FIFO_DEPTH         = 512,
    parameter int ADDR_WIDTH         = 24
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [25:0]           cfg_pixel_number,
    input  logic                  cfg_enable,
    input  logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  rresp_err,
    output logic [3:0]            mst_axi_arid,
    output logic [ADDR_WIDTH-1:0] mst_axi_araddr,
    output logic [7:0]            mst_axi_arlen,
    output logic [2:0]            mst_axi_arsize,
    output logic [1:0]            mst_axi_arburst,
    output logic                  mst_axi_arvalid,
    input  logic                  mst_axi_arready,
    input  logic [31:0]           mst_axi_rdata,
    input  logic [1:0]            mst_axi_rresp,
    input  logic                  mst_axi_rlast,
    input  logic                  mst_axi_rvalid,
    output logic                  mst_axi_rready,
    output logic [23:0]           pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eof
);
    localparam int LW = $clog2(BURST_SIZE) + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING_TR + 1);

    state_t        state;
    logic [26:0]   words_left;
    logic [CW-1:0] reserved;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] outstanding;
    logic [31:0]   fifo_rdata;
    logic [25:0]   pix_idx;
    logic [25:0]   pix_last;
    logic [1:0]    phase;
    logic [23:0]   carry;
    logic [LW-1:0] len;
    logic [LW-1:0] len_hs;
    logic [CW:0]   fill;
    logic          ar_hs, r_hs, r_last, active, go_abort, can_issue, ld, pop, accept;

    assign mst_axi_arid    = '0;
    assign mst_axi_arsize  = AXI_SIZE_4B;
    assign mst_axi_arburst = AXI_BURST_INCR;

    always_comb begin
        ar_hs     = mst_axi_arvalid && mst_axi_arready;
        r_hs      = mst_axi_rvalid && mst_axi_rready;
        r_last    = r_hs && mst_axi_rlast;
        active    = state == RUN || state == DRAIN;
        go_abort  = active && !cfg_enable;
        len       = words_left >= 27'(BURST_SIZE) ? LW'(BURST_SIZE) : LW'(words_left);
        len_hs    = LW'(mst_axi_arlen) + LW'(1);
        fill      = (CW+1)'(fifo_count) + (CW+1)'(reserved) + (CW+1)'(len);
        can_issue = state == RUN && cfg_enable && !mst_axi_arvalid && words_left != '0 &&
                    outstanding < OW'(MAX_OUTSTANDING_TR) && fill <= (CW+1)'(FIFO_DEPTH);
        accept    = pix_valid && pix_ready;
        ld        = active && cfg_enable && (!pix_valid || pix_ready) && (phase == 2'd3 || fifo_count != '0);
        pop       = ld && phase != 2'd3;
    end

    // Space is reserved at AR time, so R beats are never back-pressured
    hdmi_frame_reader_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .flush    (state == ABORT),
        .wr_en    (r_hs && state != ABORT),
        .wr_data  (mst_axi_rdata),
        .rd_en    (pop),
        .rd_data  (fifo_rdata),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            rresp_err       <= 1'b0;
            mst_axi_rready  <= 1'b0;
            mst_axi_arvalid <= 1'b0;
            mst_axi_araddr  <= '0;
            mst_axi_arlen   <= '0;
            words_left      <= '0;
            reserved        <= '0;
            outstanding     <= '0;
            pix_last        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (can_issue) begin
                mst_axi_arvalid <= 1'b1;
                mst_axi_arlen   <= 8'(len - LW'(1));
            end else if (ar_hs) begin
                mst_axi_arvalid <= 1'b0;
            end
            if (ar_hs) begin
                mst_axi_araddr <= mst_axi_araddr + ADDR_WIDTH'({len_hs, 2'b00});
                words_left     <= words_left - 27'(len_hs);
            end
            outstanding <= outstanding + OW'(ar_hs) - OW'(r_last);
            reserved    <= reserved + (ar_hs ? CW'(len_hs) : CW'(0)) - CW'(r_hs);
            if (r_hs && mst_axi_rresp != AXI_RESP_OKAY) rresp_err <= 1'b1;
            case (state)
                IDLE: if (frame_start && cfg_enable) begin
                    state          <= RUN;
                    busy           <= 1'b1;
                    mst_axi_rready <= 1'b1;
                    rresp_err      <= 1'b0;
                    mst_axi_araddr <= cfg_start_addr;
                    words_left     <= words_for(cfg_pixel_number);
                    pix_last       <= cfg_pixel_number - 26'd1;
                end
                RUN: begin
                    if (!cfg_enable) state <= ABORT;
                    else if (ar_hs && words_left == 27'(len_hs)) state <= DRAIN;
                end
                DRAIN: begin
                    if (!cfg_enable) begin
                        state <= ABORT;
                    end else if (outstanding == '0 && accept && pix_eof) begin
                        state          <= DONE;
                        frame_done     <= 1'b1;
                        mst_axi_rready <= 1'b0;
                    end
                end
                ABORT: if (outstanding == '0 && !mst_axi_arvalid) begin
                    state          <= DONE;
                    frame_done     <= 1'b1;
                    mst_axi_rready <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Unpacker: three words carry four pixels; phase 3 drains the carry
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n || !active || go_abort) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eof   <= 1'b0;
            phase     <= '0;
            carry     <= '0;
            pix_idx   <= '0;
        end else if (ld) begin
            pix_valid <= 1'b1;
            pix_data  <= phase == 2'd0 ? fifo_rdata[23:0] :
                         phase == 2'd1 ? {fifo_rdata[15:0], carry[7:0]} :
                         phase == 2'd2 ? {fifo_rdata[7:0], carry[15:0]} : carry;
            if (pop) carry <= phase == 2'd0 ? {16'd0, fifo_rdata[31:24]} :
                              phase == 2'd1 ? {8'd0, fifo_rdata[31:16]} : fifo_rdata[31:8];
            pix_sof   <= pix_idx == '0;
            pix_eof   <= pix_idx == pix_last;
            phase     <= phase + 2'd1;
            pix_idx   <= pix_idx + 26'd1;
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hdmi_frame_reader.sv
// tb_hdmi_frame_reader: randomized AXI slave and byte-addressed frame model checking the replayed pixel stream.
`timescale 1ns/1ps
module tb_hdmi_frame_reader;
    localparam int AW = 24;

    logic          clk_sys = 0;
    logic          rst_sys_n = 0;
    logic [AW-1:0] cfg_start_addr = '0;
    logic [25:0]   cfg_pixel_number = '0;
    logic          cfg_enable = 0;
    logic          frame_start = 0;
    logic          frame_done, busy, rresp_err;
    logic [3:0]    mst_axi_arid;
    logic [AW-1:0] mst_axi_araddr;
    logic [7:0]    mst_axi_arlen;
    logic [2:0]    mst_axi_arsize;
    logic [1:0]    mst_axi_arburst;
    logic          mst_axi_arvalid;
    logic          mst_axi_arready = 0;
    logic [31:0]   mst_axi_rdata = '0;
    logic [1:0]    mst_axi_rresp = '0;
    logic          mst_axi_rlast = 0;
    logic          mst_axi_rvalid = 0;
    logic          mst_axi_rready;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready = 0;
    logic          pix_sof, pix_eof;

    always #5 clk_sys = ~clk_sys;

    hdmi_frame_reader dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .cfg_start_addr(cfg_start_addr), .cfg_pixel_number(cfg_pixel_number),
        .cfg_enable(cfg_enable), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy), .rresp_err(rresp_err),
        .mst_axi_arid(mst_axi_arid), .mst_axi_araddr(mst_axi_araddr), .mst_axi_arlen(mst_axi_arlen),
        .mst_axi_arsize(mst_axi_arsize), .mst_axi_arburst(mst_axi_arburst),
        .mst_axi_arvalid(mst_axi_arvalid), .mst_axi_arready(mst_axi_arready),
        .mst_axi_rdata(mst_axi_rdata), .mst_axi_rresp(mst_axi_rresp), .mst_axi_rlast(mst_axi_rlast),
        .mst_axi_rvalid(mst_axi_rvalid), .mst_axi_rready(mst_axi_rready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eof(pix_eof)
    );

    int checks = 0;
    int errors = 0;
    int ar_rate = 50, r_rate = 70, ready_rate = 70;
    bit ready_hold = 0, abort_chk = 0;
    int err_beat = -1, beat_no = 0, out_cnt = 0;
    int unsigned f_base, f_npx, px_k, ar_exp_addr, ar_left, ar_cnt, done_cnt;
    int unsigned first_ar_addr, last_ar_addr, last_arlen;
    int unsigned beat_addr[$];
    bit beat_last[$];
    bit r_taken = 1, ar_wait = 0;
    logic [AW-1:0] ar_held;

    function automatic logic [31:0] mem_word(input int unsigned a);
        logic [31:0] w;
        w = a >> 2;
        return (w * 32'h9E3779B1) ^ (w << 7) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [7:0] mem_byte(input int unsigned a);
        return 8'(mem_word(a) >> (8 * (a & 3)));
    endfunction

    // Pixel k is bytes base+3k..base+3k+2 of a little-endian byte stream
    function automatic logic [23:0] exp_pixel(input int unsigned k);
        int unsigned a;
        a = f_base + 3 * k;
        return {mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // All inputs change at negedge; outputs are registered, so handshakes at the next posedge are known now
    always @(negedge clk_sys) begin : bus
        int unsigned len;
        if (!rst_sys_n) begin
            mst_axi_arready = 0;
            mst_axi_rvalid  = 0;
            pix_ready       = 0;
            beat_addr.delete();
            beat_last.delete();
            out_cnt = 0;
            r_taken = 1;
            ar_wait = 0;
        end else begin
            if (ar_wait) chk("ar_hold", {mst_axi_arvalid, mst_axi_araddr}, {1'b1, ar_held});
            if (!(mst_axi_rvalid && !r_taken)) begin
                mst_axi_rvalid = 0;
                if (beat_addr.size() > 0 && $urandom_range(99) < r_rate) begin
                    mst_axi_rvalid = 1;
                    mst_axi_rdata  = mem_word(beat_addr[0]);
                    mst_axi_rlast  = beat_last[0];
                    mst_axi_rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
                end
            end
            if (mst_axi_rvalid) chk("r_no_stall", mst_axi_rready, 1);
            r_taken = mst_axi_rvalid && mst_axi_rready;
            if (r_taken) begin
                if (beat_last[0]) out_cnt--;
                void'(beat_addr.pop_front());
                void'(beat_last.pop_front());
                beat_no++;
            end
            mst_axi_arready = mst_axi_arvalid && ($urandom_range(99) < ar_rate);
            ar_wait = mst_axi_arvalid && !mst_axi_arready;
            ar_held = mst_axi_araddr;
            if (mst_axi_arvalid && mst_axi_arready) begin
                len = ar_left < 128 ? ar_left : 128;
                chk("ar_addr", mst_axi_araddr, 64'(ar_exp_addr));
                chk("ar_len", mst_axi_arlen, 64'(len - 1));
                chk("ar_fixed", {mst_axi_arid, mst_axi_arsize, mst_axi_arburst}, {4'h0, 3'b010, 2'b01});
                for (int i = 0; i <= int'(mst_axi_arlen); i++) begin
                    beat_addr.push_back(int'(mst_axi_araddr) + 4 * i);
                    beat_last.push_back(i == int'(mst_axi_arlen));
                end
                if (ar_cnt == 0) first_ar_addr = mst_axi_araddr;
                last_ar_addr = mst_axi_araddr;
                last_arlen   = mst_axi_arlen;
                ar_exp_addr += 4 * len;
                ar_left     -= len;
                ar_cnt++;
                out_cnt++;
                chk("max_outstanding", out_cnt <= 2, 1);
            end
            pix_ready = ready_hold ? 0 : ($urandom_range(99) < ready_rate);
            if (abort_chk) chk("abort_pix_valid", pix_valid, 0);
            else if (pix_valid && pix_ready) begin
                chk("pix_in_range", px_k < f_npx, 1);
                chk("pix", {pix_data, pix_sof, pix_eof}, {exp_pixel(px_k), px_k == 0, px_k == f_npx - 1});
                px_k++;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic start_frame(input int unsigned base, input int unsigned npx);
        f_base = base; f_npx = npx; px_k = 0;
        ar_exp_addr = base; ar_left = npx * 3 / 4; ar_cnt = 0; done_cnt = 0;
        cfg_start_addr = AW'(base); cfg_pixel_number = 26'(npx); cfg_enable = 1;
        @(negedge clk_sys); frame_start = 1;
        @(negedge clk_sys); frame_start = 0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        chk({name, "_done_seen"}, done_cnt != 0, 1);
        @(negedge clk_sys);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_busy_cleared"}, busy, 0);
    endtask

    initial begin
        int n;
        int unsigned a;
        repeat (4) @(negedge clk_sys);
        chk("reset_ctrl", {busy, frame_done, rresp_err, mst_axi_arvalid, mst_axi_rready, pix_valid, pix_sof, pix_eof}, 0);
        chk("reset_data", {pix_data, mst_axi_araddr, mst_axi_arlen}, 0);
        rst_sys_n = 1;
        @(negedge clk_sys);

        start_frame(32'h1000, 16);
        wait_done("t1", 3000);
        chk("t1_pixels", px_k, 16);
        chk("t1_ar_count", ar_cnt, 1);
        chk("t1_ar_addr", first_ar_addr, 32'h1000);
        chk("t1_arlen", last_arlen, 11);

        start_frame(0, 1024);
        wait_done("t2", 20000);
        chk("t2_pixels", px_k, 1024);
        chk("t2_ar_count", ar_cnt, 6);
        chk("t2_last_addr", last_ar_addr, 32'hA00);

        start_frame(32'h4000, 200);
        wait_done("t3", 5000);
        chk("t3_pixels", px_k, 200);
        chk("t3_ar_count", ar_cnt, 2);
        chk("t3_last_arlen", last_arlen, 21);

        start_frame(32'h8000, 2048);
        n = 0;
        while (px_k < 100 && n < 5000) begin @(negedge clk_sys); n++; end
        chk("t4_reached_hold", px_k >= 100, 1);
        ready_hold = 1;
        repeat (1000) @(negedge clk_sys);
        a = ar_cnt;
        repeat (1000) @(negedge clk_sys);
        chk("t4_ar_paused", ar_cnt, a);
        chk("t4_ar_partial", ar_cnt < 12, 1);
        ready_hold = 0;
        wait_done("t4", 30000);
        chk("t4_pixels", px_k, 2048);
        chk("t4_ar_count", ar_cnt, 12);

        ar_rate = 3; r_rate = 5;
        start_frame(0, 4096);
        n = 0;
        while (!(mst_axi_arvalid && out_cnt == 1) && n < 5000) begin @(negedge clk_sys); n++; end
        chk("t5_pending_setup", mst_axi_arvalid && out_cnt == 1, 1);
        cfg_enable = 0;
        @(negedge clk_sys);
        abort_chk = 1; ar_rate = 40; r_rate = 60;
        wait_done("t5", 10000);
        abort_chk = 0;
        chk("t5_beats_drained", beat_addr.size(), 0);
        chk("t5_outstanding", out_cnt, 0);
        chk("t5_pix_idle", pix_valid, 0);
        cfg_enable = 1;
        ar_rate = 50; r_rate = 70;

        err_beat = beat_no + 30;
        start_frame(32'h3000, 200);
        repeat (20) @(negedge clk_sys);
        cfg_start_addr = 24'h00C000;
        frame_start = 1;
        @(negedge clk_sys);
        frame_start = 0;
        cfg_start_addr = 24'h003000;
        wait_done("t6", 5000);
        chk("t6_pixels", px_k, 200);
        chk("t6_ar_count", ar_cnt, 2);
        chk("t6_rresp_err", rresp_err, 1);
        err_beat = -1;

        start_frame(32'h2000, 16);
        chk("t7_rresp_cleared", rresp_err, 0);
        wait_done("t7", 3000);
        chk("t7_pixels", px_k, 16);
        chk("t7_rresp_still_clear", rresp_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
